// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared states, parity modes and timing helper for the UART receiver
// Optional macro UART_RX_BREAK_DETECT_EN adds the BREAK_WAIT state.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        CLEANUP
`ifdef UART_RX_BREAK_DETECT_EN
        ,
        BREAK_WAIT
`endif
    } rx_state_t;

    // Whole clock cycles per bit; the fraction is dropped.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for an idle-high serial line
// Ports: clk, reset (sync, active-high), line (async in), synced (out, resets to 1).
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic synced
);

    logic meta;

    // Reset to 1 so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta   <= 1'b1;
            synced <= 1'b1;
        end else begin
            meta   <= line;
            synced <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with parity and framing checks
// Ports: i_Clock, i_Reset (sync, active-high), i_Rx_Serial (async, idles high);
//        o_Rx_DV (1-cycle word strobe), o_Rx_Byte, o_Parity_Err, o_Frame_Err (held until
//        next strobe), o_Busy (not IDLE), o_Break (only with UART_RX_BREAK_DETECT_EN).
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = clks_per_bit(50_000_000, 9600),
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = PARITY_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
`ifdef UART_RX_BREAK_DETECT_EN
    output logic                 o_Break,
`endif
    output logic                 o_Busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t            state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic [DATA_BITS-1:0] data, data_n;
    logic                 par_bit, par_bit_n;
    logic                 ferr_acc, ferr_acc_n;
    logic                 dv_n, perr_n, ferr_n;
    logic [DATA_BITS-1:0] byte_n;
    logic                 rx;
    logic                 data_xor;
    logic                 par_err;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                 brk_n;
    logic                 break_hit;
`endif

    uart_rx_sync u_sync (
        .clk    (i_Clock),
        .reset  (i_Reset),
        .line   (i_Rx_Serial),
        .synced (rx)
    );

    assign o_Busy   = (state != IDLE);
    assign data_xor = (^data) ^ par_bit;

    always_comb begin
        par_err = 1'b0;
        if (PARITY_MODE == PARITY_ODD)       par_err = ~data_xor;
        else if (PARITY_MODE == PARITY_EVEN) par_err = data_xor;
    end

`ifdef UART_RX_BREAK_DETECT_EN
    // Evaluated on the last stop sample: all-zero word, zero parity, bad stop.
    assign break_hit = (data == '0) && ((PARITY_MODE == PARITY_NONE) || !par_bit)
                       && (ferr_acc || !rx);
`endif

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        idx_n      = idx;
        data_n     = data;
        par_bit_n  = par_bit;
        ferr_acc_n = ferr_acc;
        dv_n       = 1'b0;
        byte_n     = o_Rx_Byte;
        perr_n     = o_Parity_Err;
        ferr_n     = o_Frame_Err;
`ifdef UART_RX_BREAK_DETECT_EN
        brk_n      = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rx) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_n = '0;
                    if (!rx) begin
                        state_n    = DATA;
                        idx_n      = '0;
                        ferr_acc_n = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    for (int i = 0; i < DATA_BITS; i++) begin
                        if (idx == IDX_W'(i)) data_n[i] = rx;
                    end
                    if (idx == IDX_W'(DATA_BITS - 1)) begin
                        idx_n   = '0;
                        state_n = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            PARITY: begin
                if (cnt == CNT_LAST) begin
                    cnt_n     = '0;
                    par_bit_n = rx;
                    state_n   = STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n      = '0;
                    ferr_acc_n = ferr_acc | ~rx;
                    if (idx == IDX_W'(STOP_BITS - 1)) begin
                        idx_n   = '0;
                        dv_n    = 1'b1;
                        byte_n  = data;
                        perr_n  = par_err;
                        ferr_n  = ferr_acc | ~rx;
                        // Re-arm while still inside the stop bit so back-to-back
                        // frames are not lost.
                        state_n = CLEANUP;
`ifdef UART_RX_BREAK_DETECT_EN
                        if (break_hit) begin
                            brk_n   = 1'b1;
                            state_n = BREAK_WAIT;
                        end
`endif
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            CLEANUP: begin
                state_n = IDLE;
            end
`ifdef UART_RX_BREAK_DETECT_EN
            // Require a full bit time of continuous high before listening again.
            BREAK_WAIT: begin
                if (!rx) begin
                    cnt_n = '0;
                end else if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`endif
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            data         <= '0;
            par_bit      <= 1'b0;
            ferr_acc     <= 1'b0;
            o_Rx_DV      <= 1'b0;
            o_Rx_Byte    <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            o_Break      <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            idx          <= idx_n;
            data         <= data_n;
            par_bit      <= par_bit_n;
            ferr_acc     <= ferr_acc_n;
            o_Rx_DV      <= dv_n;
            o_Rx_Byte    <= byte_n;
            o_Parity_Err <= perr_n;
            o_Frame_Err  <= ferr_n;
`ifdef UART_RX_BREAK_DETECT_EN
            o_Break      <= brk_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed table-driven bench for uart_rx_param
module tb_uart_rx_param;

    localparam int CPB  = 16;
    localparam int HALF = (CPB - 1) / 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       rx0 = 1'b1, rx1 = 1'b1;
    logic       dv0, perr0, ferr0, busy0;
    logic       dv1, perr1, ferr1, busy1;
    logic [7:0] byte0, byte1;
`ifdef UART_RX_BREAK_DETECT_EN
    logic       brk0, brk1;
    int         brk_cnt = 0;
`endif

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
        .i_Clock      (clk),
        .i_Reset      (reset),
        .i_Rx_Serial  (rx0),
        .o_Rx_DV      (dv0),
        .o_Rx_Byte    (byte0),
        .o_Parity_Err (perr0),
        .o_Frame_Err  (ferr0),
`ifdef UART_RX_BREAK_DETECT_EN
        .o_Break      (brk0),
`endif
        .o_Busy       (busy0)
    );

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2)) u1 (
        .i_Clock      (clk),
        .i_Reset      (reset),
        .i_Rx_Serial  (rx1),
        .o_Rx_DV      (dv1),
        .o_Rx_Byte    (byte1),
        .o_Parity_Err (perr1),
        .o_Frame_Err  (ferr1),
`ifdef UART_RX_BREAK_DETECT_EN
        .o_Break      (brk1),
`endif
        .o_Busy       (busy1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] b;
        logic       pe;
        logic       fe;
        int         at;
    } rec_t;

    rec_t q0[$];
    rec_t q1[$];

    always @(negedge clk) begin
        if (dv0) q0.push_back('{b: byte0, pe: perr0, fe: ferr0, at: cyc});
        if (dv1) q1.push_back('{b: byte1, pe: perr1, fe: ferr1, at: cyc});
`ifdef UART_RX_BREAK_DETECT_EN
        if (brk0) brk_cnt++;
`endif
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input int which, input logic v);
        if (which == 0) rx0 = v;
        else rx1 = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Start bit, then nwire bits of w LSB first; t0 = cycle count at the start edge.
    task automatic send_frame(input int which, input logic [15:0] w, input int nwire, output int t0);
        t0 = cyc;
        drive_bit(which, 1'b0);
        for (int i = 0; i < nwire; i++) drive_bit(which, w[i]);
    endtask

    task automatic idle_line(input int which, input int nbits);
        for (int i = 0; i < nbits; i++) drive_bit(which, 1'b1);
    endtask

    // Strobe lands nwire*CPB + HALF + 3 cycles after the first sampling edge,
    // which is one edge after the bench drives the start bit.
    task automatic expect_frame(input string name, input int which, input logic [7:0] b,
                                input logic pe, input logic fe, input int t0, input int nwire);
        rec_t r;
        int   sz;
        sz = (which == 0) ? q0.size() : q1.size();
        check({name, " strobe present"}, 32'(sz != 0), 1);
        if (sz != 0) begin
            if (which == 0) r = q0.pop_front();
            else r = q1.pop_front();
            check({name, " word"}, 32'(r.b), 32'(b));
            check({name, " parity_err"}, 32'(r.pe), 32'(pe));
            check({name, " frame_err"}, 32'(r.fe), 32'(fe));
            check({name, " latency"}, 32'(r.at - t0), 32'(nwire * CPB + HALF + 4));
        end
    endtask

    typedef struct {
        int          which;
        logic [15:0] w;
        int          nwire;
        logic [7:0]  b;
        logic        pe;
        logic        fe;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int t0, t1;

        // u0: 8N1; u1: 8 data, even parity, two stop bits.
        vecs[0] = '{0, 16'h01A8,  9, 8'hA8, 1'b0, 1'b0};
        vecs[1] = '{0, 16'h0100,  9, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{0, 16'h00FF,  9, 8'hFF, 1'b0, 1'b1};
        vecs[3] = '{0, 16'h015A,  9, 8'h5A, 1'b0, 1'b0};
        vecs[4] = '{1, 16'h07A8, 11, 8'hA8, 1'b0, 1'b0};
        vecs[5] = '{1, 16'h06A8, 11, 8'hA8, 1'b1, 1'b0};
        vecs[6] = '{1, 16'h020F, 11, 8'h0F, 1'b0, 1'b1};
        vecs[7] = '{1, 16'h050F, 11, 8'h0F, 1'b1, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("reset dv", 32'(dv0), 0);
        check("reset byte", 32'(byte0), 0);
        check("reset parity_err", 32'(perr0), 0);
        check("reset frame_err", 32'(ferr0), 0);
        check("reset busy", 32'(busy0), 0);
        reset = 1'b0;
        idle_line(0, 2);

        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].which, vecs[i].w, vecs[i].nwire, t0);
            idle_line(vecs[i].which, 3);
            expect_frame($sformatf("vec%0d", i), vecs[i].which, vecs[i].b, vecs[i].pe,
                         vecs[i].fe, t0, vecs[i].nwire);
            check($sformatf("vec%0d single strobe", i),
                  32'((vecs[i].which == 0) ? q0.size() : q1.size()), 0);
        end

        // Back-to-back frames with no idle gap.
        send_frame(0, 16'h010F, 9, t0);
        send_frame(0, 16'h0105, 9, t1);
        idle_line(0, 3);
        expect_frame("b2b first", 0, 8'h0F, 1'b0, 1'b0, t0, 9);
        expect_frame("b2b second", 0, 8'h05, 1'b0, 1'b0, t1, 9);
        check("b2b strobe count", 32'(q0.size()), 0);

        // Short low glitch on an idle line.
        rx0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx0 = 1'b1;
        @(posedge clk);
        #1;
        check("glitch busy raised", 32'(busy0), 1);
        repeat (HALF + 1) @(posedge clk);
        #1;
        check("glitch busy cleared", 32'(busy0), 0);
        idle_line(0, 12);
        check("glitch no strobe", 32'(q0.size()), 0);

        // Reset in the middle of data bit 4 of an 0xA8 frame.
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, (i == 3));
        rx0 = 1'b0;
        repeat (CPB / 2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset dv", 32'(dv0), 0);
        check("midreset byte", 32'(byte0), 0);
        check("midreset parity_err", 32'(perr0), 0);
        check("midreset frame_err", 32'(ferr0), 0);
        check("midreset busy", 32'(busy0), 0);
        reset = 1'b0;
        idle_line(0, 12);
        check("midreset no strobe", 32'(q0.size()), 0);
        send_frame(0, 16'h01A8, 9, t0);
        idle_line(0, 2);
        expect_frame("after reset", 0, 8'hA8, 1'b0, 1'b0, t0, 9);

`ifdef UART_RX_BREAK_DETECT_EN
        // Line held low for three frame times, then released.
        rx0 = 1'b0;
        repeat (30 * CPB) @(posedge clk);
        #1;
        check("break pulses", 32'(brk_cnt), 1);
        check("break strobes", 32'(q0.size()), 1);
        if (q0.size() != 0) begin
            rec_t r;
            r = q0.pop_front();
            check("break word", 32'(r.b), 0);
            check("break frame_err", 32'(r.fe), 1);
        end
        rx0 = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        #1;
        check("break still waiting", 32'(busy0), 1);
        idle_line(0, 2);
        check("break released", 32'(busy0), 0);
        check("break no extra strobe", 32'(q0.size()), 0);
        send_frame(0, 16'h01A8, 9, t0);
        idle_line(0, 2);
        expect_frame("after break", 0, 8'hA8, 1'b0, 1'b0, t0, 9);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
